counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
- Programmable sequencer for the 4-bit ripple-carry up-counter datapath.
- Accepts a configuration (preload, mode, prescale) over a valid/ready handshake, then starts, pauses, reloads and stops the counter.
- Emits a one-cycle tick on each terminal-count rollover, equivalent to the carry output of the plain counter.
- Sits between a host or control FSM and the counter, so counter timing becomes software-controllable: one-shot or periodic.

Parameters:
- WIDTH, 4, counter width in bits; terminal value is all-ones, 2^WIDTH-1.
- PW, 4, prescale field width; one counter step every (presc+1) clk cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted.
- cfg_load  in  WIDTH  preload value L.
- cfg_mode  in  1  0 = one-shot, 1 = periodic.
- cfg_presc  in  PW  prescale value P.
- start  in  1  start/resume request (level sampled each edge).
- stop  in  1  pause/abort request.
- count  out  WIDTH  current counter value.
- tick  out  1  one-cycle registered pulse on terminal rollover.
- busy  out  1  high in LOAD and RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; count=0, tick=0, busy=0, done=0, cfg_ready=1.
  - Latched cfg regs: L=0, mode=0, P=0. Prescale counter = 0.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- cfg_ready=1 only in IDLE and DONE.
  - Transfer when cfg_valid&&cfg_ready at an edge; the regs update that edge.
  - Config offered in other states is held off, not dropped.
- IDLE / DONE:
  - start -> LOAD. A start with no prior config runs with the reset config.
  - A cfg transfer and start on the same edge: the new config is used.
  - DONE holds done=1 until it leaves DONE.
- LOAD: one cycle.
  - Next edge: count<=L, prescale cnt<=0, ->RUN.
  - stop during LOAD -> IDLE, count<=L.
- RUN:
  - Prescale cnt increments each cycle. When it equals P: cnt<=0 and a step occurs.
  - Step with count<all-ones: count<=count+1.
  - Step with count==all-ones: tick<=1 for exactly one cycle.
    - Periodic: count<=L, stay RUN.
    - One-shot: count holds all-ones, ->DONE.
  - Period (periodic) = (2^WIDTH-L)*(P+1) cycles. L=all-ones gives 1 step per period.
  - stop (no step) -> PAUSE; count and prescale cnt hold.
- PAUSE:
  - start&&!stop -> RUN, resuming the prescale phase.
  - stop -> IDLE, count holds its last value.
- Simultaneous events:
  - start&&stop: stop wins in every state.
  - Terminal step && stop in RUN:
    - tick still fires and the reload/terminal action still occurs.
    - Periodic -> PAUSE with count=L.
    - One-shot -> DONE (stop ignored).
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs except none. cfg_ready is decoded from state.
- Arithmetic is unsigned. Increment never exceeds WIDTH; the rollover is handled explicitly, no silent wrap.

Decomposition:
- Shared header/package (counter_seq_defs):
  - State encodings S_IDLE..S_DONE (3-bit).
  - MODE_ONESHOT=0, MODE_PERIODIC=1.
- One sub-module, counter_core:
  - Ports: clk, rst, en, ld, d[WIDTH] -> q[WIDTH], rc.
  - rc = en && q==all-ones.
  - It is the loadable up-counter. The controller drives en (step) and ld (LOAD state or periodic reload), and uses rc as the terminal condition.

Test Plan:
- Reset mid-RUN (L=3, P=0, count=7), assert rst asynchronously between edges -> count=0, tick=0, busy=0, cfg_ready=1 immediately; L/mode/P read back as 0 on the next run.
- cfg L=13, one-shot, P=0; start at edge E0:
  - E1: count=13, busy=1.
  - E2: count=14. E3: count=15.
  - E4: tick=1, state DONE, done=1, count=15.
  - E5: tick=0.
- cfg L=14, periodic, P=1; start -> tick every 4 cycles, with count sequence 14,14,15,15,14 across 4 cycles. Sustained for 5 periods, with no missed or double ticks.
- Pause/resume: periodic L=0, P=2. stop while count=5 -> PAUSE, count=5 held 10 cycles. start -> count=6 after the remaining prescale cycles. start&&stop in PAUSE -> IDLE.
- Handshake: cfg_valid held during RUN -> cfg_ready=0, no transfer. On entry to DONE/IDLE the transfer completes in that cycle and the new L is used by the next start.
- Collision: periodic L=15, P=0. stop asserted on the terminal-step cycle -> tick=1, count=15 (reload), state PAUSE. The same test with one-shot -> DONE.

Source files
------------

// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencer: controller state encoding and
// the one-shot/periodic mode codes.
package counter_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_seq_ctrl_core.sv
// Loadable up-counter datapath. rc flags a step requested at all-ones; the
// counter then holds instead of wrapping, leaving the rollover to the controller.
module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rc
);

    assign rc = en && (q == {WIDTH{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (en && !rc) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer around counter_core: accepts a config over valid/ready, then runs
// the counter one-shot or periodically with a prescaler, pause and abort.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_load,
    input  logic             cfg_mode,
    input  logic [PW-1:0]    cfg_presc,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] load_q;
    logic             mode_q;
    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    pcnt;
    logic             cfg_fire;
    logic             step;
    logic             core_ld;
    logic             core_rc;

    assign cfg_ready = (state == S_IDLE) || (state == S_DONE);
    assign busy      = (state == S_LOAD) || (state == S_RUN);
    assign done      = (state == S_DONE);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign step      = (state == S_RUN) && (pcnt == presc_q);
    assign core_ld   = (state == S_LOAD) || (core_rc && (mode_q == MODE_PERIODIC));

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk (clk),
        .rst (rst),
        .en  (step),
        .ld  (core_ld),
        .d   (load_q),
        .q   (count),
        .rc  (core_rc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A step due on the same edge as stop still happens; stop only picks the next state.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start && !stop) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (core_rc && (mode_q == MODE_ONESHOT)) begin
                    state_next = S_DONE;
                end else if (stop) begin
                    state_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_next = S_IDLE;
                end else if (start) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q  <= '0;
            mode_q  <= MODE_ONESHOT;
            presc_q <= '0;
        end else if (cfg_fire) begin
            load_q  <= cfg_load;
            mode_q  <= cfg_mode;
            presc_q <= cfg_presc;
        end
    end

    // The prescale phase freezes while stopping or paused so a resume continues mid-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (state == S_LOAD) begin
            pcnt <= '0;
        end else if (state == S_RUN) begin
            if (step) begin
                pcnt <= '0;
            end else if (!stop) begin
                pcnt <= pcnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= core_rc;
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: directed scenarios plus random
// stimulus, all compared against a cycle-level behavioural model.
module tb_counter_seq_ctrl;

    localparam int TERM = 15;
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

    logic       clk, rst;
    logic       cfg_valid, cfg_ready, cfg_mode;
    logic [3:0] cfg_load, cfg_presc, count;
    logic       start, stop, tick, busy, done;

    int errors = 0;
    int checks = 0;

    int m_state, m_count, m_phase, m_L, m_mode, m_P, m_tick;

    counter_seq_ctrl #(.WIDTH(4), .PW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_load  (cfg_load),
        .cfg_mode  (cfg_mode),
        .cfg_presc (cfg_presc),
        .start     (start),
        .stop      (stop),
        .count     (count),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_count = 0;
        m_phase = 0;
        m_L     = 0;
        m_mode  = 0;
        m_P     = 0;
        m_tick  = 0;
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        int nstate;
        nstate = m_state;
        m_tick = 0;
        case (m_state)
            M_IDLE, M_DONE: begin
                if (cfg_valid) begin
                    m_L    = int'(cfg_load);
                    m_mode = int'(cfg_mode);
                    m_P    = int'(cfg_presc);
                end
                if (start && !stop) nstate = M_LOAD;
            end
            M_LOAD: begin
                m_count = m_L;
                m_phase = 0;
                nstate  = stop ? M_IDLE : M_RUN;
            end
            M_RUN: begin
                if (m_phase == m_P) begin
                    m_phase = 0;
                    if (m_count == TERM) begin
                        m_tick = 1;
                        if (m_mode == 1) begin
                            m_count = m_L;
                            if (stop) nstate = M_PAUSE;
                        end else begin
                            nstate = M_DONE;
                        end
                    end else begin
                        m_count = m_count + 1;
                        if (stop) nstate = M_PAUSE;
                    end
                end else if (stop) begin
                    nstate = M_PAUSE;
                end else begin
                    m_phase = m_phase + 1;
                end
            end
            M_PAUSE: begin
                if (stop) nstate = M_IDLE;
                else if (start) nstate = M_RUN;
            end
            default: nstate = M_IDLE;
        endcase
        m_state = nstate;
    endtask

    task automatic apply_stimulus(input logic s, input logic p, input logic v,
                                  input logic [3:0] l, input logic m, input logic [3:0] pr);
        start     = s;
        stop      = p;
        cfg_valid = v;
        cfg_load  = l;
        cfg_mode  = m;
        cfg_presc = pr;
    endtask

    task automatic check_output();
        chk("count", 32'(count), 32'(m_count));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("busy", 32'(busy), 32'((m_state == M_LOAD) || (m_state == M_RUN)));
        chk("done", 32'(done), 32'(m_state == M_DONE));
        chk("cfg_ready", 32'(cfg_ready), 32'((m_state == M_IDLE) || (m_state == M_DONE)));
    endtask

    task automatic clock_cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        int tick_seen;
        rst = 1'b1;
        apply_stimulus(0, 0, 0, 4'd0, 0, 4'd0);
        model_reset();
        #17;
        check_output();
        rst = 1'b0;

        $display("[TB] one-shot L=13 P=0");
        apply_stimulus(1, 0, 1, 4'd13, 0, 4'd0);
        clock_cycle();
        chk("A_load_busy", 32'(busy), 32'd1);
        apply_stimulus(0, 0, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        chk("A_E1_count", 32'(count), 32'd13);
        clock_cycle();
        chk("A_E2_count", 32'(count), 32'd14);
        clock_cycle();
        chk("A_E3_count", 32'(count), 32'd15);
        clock_cycle();
        chk("A_E4_tick", 32'(tick), 32'd1);
        chk("A_E4_done", 32'(done), 32'd1);
        chk("A_E4_count", 32'(count), 32'd15);
        clock_cycle();
        chk("A_E5_tick", 32'(tick), 32'd0);
        chk("A_E5_done", 32'(done), 32'd1);

        $display("[TB] periodic L=14 P=1");
        apply_stimulus(1, 0, 1, 4'd14, 1, 4'd1);
        clock_cycle();
        apply_stimulus(0, 0, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        chk("B_load_count", 32'(count), 32'd14);
        tick_seen = 0;
        for (int i = 0; i < 20; i++) begin
            clock_cycle();
            if (tick) tick_seen++;
            chk("B_tick_phase", 32'(tick), 32'((i % 4) == 3));
        end
        chk("B_tick_total", 32'(tick_seen), 32'd5);
        apply_stimulus(0, 1, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        clock_cycle();
        chk("B_stop_idle", 32'(cfg_ready), 32'd1);

        $display("[TB] pause/resume L=0 P=2");
        apply_stimulus(1, 0, 1, 4'd0, 1, 4'd2);
        clock_cycle();
        apply_stimulus(0, 0, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        for (int i = 0; i < 60; i++) begin
            if (m_count == 5 && m_phase == 1) break;
            clock_cycle();
        end
        apply_stimulus(0, 1, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        chk("C_paused_busy", 32'(busy), 32'd0);
        apply_stimulus(0, 0, 0, 4'd0, 0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            clock_cycle();
            chk("C_hold_count", 32'(count), 32'd5);
        end
        apply_stimulus(1, 0, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        apply_stimulus(0, 0, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        chk("C_resume_wait", 32'(count), 32'd5);
        clock_cycle();
        chk("C_resume_step", 32'(count), 32'd6);
        apply_stimulus(1, 1, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        clock_cycle();
        chk("C_abort_ready", 32'(cfg_ready), 32'd1);
        chk("C_abort_count", 32'(count), 32'd6);

        $display("[TB] collision L=15 P=0");
        apply_stimulus(1, 0, 1, 4'd15, 1, 4'd0);
        clock_cycle();
        apply_stimulus(0, 0, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        apply_stimulus(0, 1, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        chk("E_per_tick", 32'(tick), 32'd1);
        chk("E_per_count", 32'(count), 32'd15);
        chk("E_per_pause", 32'(busy | done | cfg_ready), 32'd0);
        clock_cycle();
        apply_stimulus(1, 0, 1, 4'd15, 0, 4'd0);
        clock_cycle();
        apply_stimulus(0, 0, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        apply_stimulus(0, 1, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        chk("E_one_tick", 32'(tick), 32'd1);
        chk("E_one_done", 32'(done), 32'd1);

        $display("[TB] handshake hold-off");
        apply_stimulus(1, 0, 1, 4'd9, 0, 4'd0);
        clock_cycle();
        apply_stimulus(0, 0, 1, 4'd2, 0, 4'd0);
        for (int i = 0; i < 12; i++) clock_cycle();
        apply_stimulus(1, 0, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        apply_stimulus(0, 0, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        chk("D_new_load", 32'(count), 32'd2);
        for (int i = 0; i < 16; i++) clock_cycle();

        $display("[TB] random stimulus");
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 3) == 0,
                           4'($urandom), 1'($urandom), 4'($urandom % 4));
            clock_cycle();
        end

        $display("[TB] async reset mid-run");
        apply_stimulus(0, 1, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        clock_cycle();
        apply_stimulus(1, 0, 1, 4'd3, 1, 4'd0);
        clock_cycle();
        apply_stimulus(0, 0, 0, 4'd0, 0, 4'd0);
        for (int i = 0; i < 20; i++) begin
            clock_cycle();
            if (m_count == 7) break;
        end
        chk("R_pre_count", 32'(count), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_output();
        #2;
        rst = 1'b0;
        apply_stimulus(1, 0, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        apply_stimulus(0, 0, 0, 4'd0, 0, 4'd0);
        clock_cycle();
        chk("R_L_zero", 32'(count), 32'd0);
        clock_cycle();
        chk("R_P_zero", 32'(count), 32'd1);
        for (int i = 0; i < 15; i++) clock_cycle();
        chk("R_mode_oneshot", 32'(done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
